// File: rtl/channel_monitor_arbiter_if.sv
// Bus bundle for channel_monitor_arbiter: N ready-valid input channels plus one tagged monitor output.
// The master modport is the arbiter side; slave is the sources/monitor sink side.
interface channel_monitor_arbiter_if #(
    parameter int unsigned NUM_INPUTS = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned IDX_WIDTH  = 2
);
    localparam int unsigned IN_DATA_WIDTH = NUM_INPUTS * DATA_WIDTH;
    localparam int unsigned OUT_WIDTH     = IDX_WIDTH + DATA_WIDTH;

    logic [NUM_INPUTS-1:0]    in_valid;
    logic [IN_DATA_WIDTH-1:0] in_data;
    logic [NUM_INPUTS-1:0]    in_ready;
    logic                     out_valid;
    logic [OUT_WIDTH-1:0]     out_data;
    logic                     out_ready;
    logic                     busy;

    modport master (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output busy
    );

    modport slave (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  busy
    );
endinterface

// File: rtl/channel_monitor_arbiter.sv
// Round-robin merge of N ready-valid channels into one registered, source-tagged monitor channel.
// Optional saturating stall counter enabled by CHANNEL_MONITOR_ARBITER_STALL_COUNT_EN.
module channel_monitor_arbiter #(
    parameter int unsigned NUM_INPUTS = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned IDX_WIDTH  = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    channel_monitor_arbiter_if.master     bus
`ifdef CHANNEL_MONITOR_ARBITER_STALL_COUNT_EN
    ,
    output logic [15:0]                   stall_count
`endif
);
    localparam int unsigned OUT_WIDTH = IDX_WIDTH + DATA_WIDTH;
    localparam int unsigned SUM_WIDTH = IDX_WIDTH + 1;

    // Elaboration-time parameter legality
    generate
        if (NUM_INPUTS < 2 || NUM_INPUTS > 8) begin : g_bad_num_inputs
            $error("channel_monitor_arbiter: NUM_INPUTS must be in 2..8");
        end
        if (IDX_WIDTH != $clog2(NUM_INPUTS)) begin : g_bad_idx_width
            $error("channel_monitor_arbiter: IDX_WIDTH must equal ceil(log2(NUM_INPUTS))");
        end
    endgenerate

    logic                  out_valid_q, out_valid_d;
    logic [OUT_WIDTH-1:0]  out_data_q,  out_data_d;
    logic [IDX_WIDTH-1:0]  rr_ptr_q,    rr_ptr_d;

    logic                  load_en;
    logic                  grant_found;
    logic [IDX_WIDTH-1:0]  grant_idx;
    logic [SUM_WIDTH-1:0]  cand_sum;
    logic [NUM_INPUTS-1:0] grant_onehot;
    logic [DATA_WIDTH-1:0] grant_payload;

    assign load_en = !out_valid_q || bus.out_ready;

    // First valid input at or after rr_ptr, wrapping modulo NUM_INPUTS
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_sum    = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            cand_sum = {1'b0, rr_ptr_q} + SUM_WIDTH'(k);
            if (cand_sum >= SUM_WIDTH'(NUM_INPUTS)) begin
                cand_sum = cand_sum - SUM_WIDTH'(NUM_INPUTS);
            end
            if (!grant_found && bus.in_valid[cand_sum[IDX_WIDTH-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand_sum[IDX_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        grant_payload = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (grant_idx == IDX_WIDTH'(i)) begin
                grant_payload = bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign grant_onehot = grant_found ? (NUM_INPUTS'(1) << grant_idx) : '0;

    // Ready only while out of reset and the output stage can take a word
    assign bus.in_ready  = (rst_n && load_en) ? grant_onehot : '0;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.busy      = out_valid_q || (|bus.in_valid);

    // Output stage next state; drain and reload share one edge
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        rr_ptr_d    = rr_ptr_q;
        if (load_en) begin
            if (grant_found) begin
                out_valid_d = 1'b1;
                out_data_d  = {grant_idx, grant_payload};
                rr_ptr_d    = (grant_idx == IDX_WIDTH'(NUM_INPUTS - 1))
                            ? '0 : grant_idx + IDX_WIDTH'(1);
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

`ifdef CHANNEL_MONITOR_ARBITER_STALL_COUNT_EN
    logic [15:0] stall_count_d;

    // Saturating count of cycles the monitor sink holds off a valid word
    always_comb begin
        stall_count_d = stall_count;
        if (out_valid_q && !bus.out_ready && stall_count != 16'hFFFF) begin
            stall_count_d = stall_count + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= 16'd0;
        end else begin
            stall_count <= stall_count_d;
        end
    end
`endif

endmodule

// File: tb/tb_channel_monitor_arbiter.sv
// Scoreboard bench for channel_monitor_arbiter: directed scenarios plus randomized traffic.
module tb_channel_monitor_arbiter;
    localparam int unsigned N  = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned IW = 2;
    localparam int unsigned OW = IW + DW;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    channel_monitor_arbiter_if #(.NUM_INPUTS(N), .DATA_WIDTH(DW), .IDX_WIDTH(IW)) bus ();

`ifdef CHANNEL_MONITOR_ARBITER_STALL_COUNT_EN
    logic [15:0] stall_count;
`endif

    channel_monitor_arbiter #(.NUM_INPUTS(N), .DATA_WIDTH(DW), .IDX_WIDTH(IW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.master)
`ifdef CHANNEL_MONITOR_ARBITER_STALL_COUNT_EN
        ,
        .stall_count (stall_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural reference: expected words are queued when a transfer is predicted
    logic [OW-1:0] sb[$];
    logic          m_valid;
    logic [OW-1:0] m_data;
    int            m_rr;
    logic          m_load;
    logic          m_found;
    int            m_g;
    int            m_c;
    logic [N-1:0]  m_rdy;
    logic [OW-1:0] exp_w;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_rr    = 0;
            sb.delete();
        end else begin
            check("busy", 32'(bus.busy), 32'(m_valid || (|bus.in_valid)));
            check("out_valid", 32'(bus.out_valid), 32'(m_valid));
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    exp_w = sb.pop_front();
                    check("sb_word", 32'(bus.out_data), 32'(exp_w));
                end
            end
            m_load  = !m_valid || bus.out_ready;
            m_found = 1'b0;
            m_g     = 0;
            for (int k = 0; k < N; k++) begin
                m_c = (m_rr + k) % N;
                if (!m_found && bus.in_valid[m_c]) begin
                    m_found = 1'b1;
                    m_g     = m_c;
                end
            end
            m_rdy = (m_load && m_found) ? (N'(1) << m_g) : '0;
            check("in_ready", 32'(bus.in_ready), 32'(m_rdy));
            if (m_load) begin
                if (m_found) begin
                    m_valid = 1'b1;
                    m_data  = {IW'(m_g), bus.in_data[m_g*DW +: DW]};
                    m_rr    = (m_g + 1) % N;
                    sb.push_back(m_data);
                end else begin
                    m_valid = 1'b0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int idx, input logic [DW-1:0] d);
        bus.in_data[idx*DW +: DW] = d;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    logic [OW-1:0] rr_exp;

    initial begin
        errors        = 0;
        checks        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 4'hF;
        bus.in_data   = 32'h44332211;
        bus.out_ready = 1'b1;

        // Reset/idle
        #3;
        check("rst_in_ready", 32'(bus.in_ready), 32'h0);
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_out_data", 32'(bus.out_data), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h1);
        step();
        step();
        bus.in_valid = '0;
        rst_n        = 1'b1;
        step();
        step();
        check("idle_out_valid", 32'(bus.out_valid), 32'h0);
        check("idle_busy", 32'(bus.busy), 32'h0);

        // Single input
        bus.in_valid = 4'b0100;
        set_data(2, 8'hA5);
        #1;
        check("single_in_ready", 32'(bus.in_ready), 32'h4);
        step();
        bus.in_valid = '0;
        check("single_out_valid", 32'(bus.out_valid), 32'h1);
        check("single_out_data", 32'(bus.out_data), 32'h2A5);
        step();

        // Round-robin with all inputs valid, from a fresh pointer
        reset_pulse();
        for (int i = 0; i < N; i++) set_data(i, DW'(8'h10 + i));
        bus.in_valid = 4'hF;
        for (int k = 0; k < 6; k++) begin
            step();
            rr_exp = {IW'(k % N), DW'(8'h10 + (k % N))};
            check("rr_word", 32'(bus.out_data), 32'(rr_exp));
        end
        bus.in_valid = '0;
        step();

        // Backpressure: hold {1,3C} while inputs 0 and 3 wait
        bus.in_valid  = 4'b0010;
        set_data(1, 8'h3C);
        set_data(0, 8'h55);
        set_data(3, 8'hAA);
        bus.out_ready = 1'b0;
        step();
        bus.in_valid = 4'b1001;
        #1;
        check("bp_load", 32'(bus.out_data), 32'h13C);
        for (int k = 0; k < 5; k++) begin
            step();
            check("bp_in_ready", 32'(bus.in_ready), 32'h0);
            check("bp_hold", 32'(bus.out_data), 32'h13C);
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(bus.in_ready), 32'h8);
        step();
        check("bp_word3", 32'(bus.out_data), 32'h3AA);
        check("bp_next_ready", 32'(bus.in_ready), 32'h1);
        step();
        check("bp_word0", 32'(bus.out_data), 32'h055);
        bus.in_valid = '0;

        // Reset mid-stream with a pending word and rr_ptr at 2
        step();
        bus.in_valid  = 4'b0010;
        bus.out_ready = 1'b0;
        set_data(1, 8'h61);
        set_data(2, 8'h62);
        step();
        check("mid_pending", 32'(bus.out_valid), 32'h1);
        bus.in_valid = 4'b0110;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_async_valid", 32'(bus.out_valid), 32'h0);
        check("mid_async_ready", 32'(bus.in_ready), 32'h0);
        step();
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        check("mid_first_ready", 32'(bus.in_ready), 32'h2);
        step();
        check("mid_first_word", 32'(bus.out_data), 32'h161);
        bus.in_valid = '0;
        step();

        // Randomized traffic against the scoreboard
        for (int k = 0; k < 300; k++) begin
            bus.in_valid  = N'($urandom_range(0, 15));
            bus.in_data   = $urandom();
            bus.out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        bus.in_valid  = '0;
        bus.out_ready = 1'b1;
        step();
        step();
        check("sb_drained", 32'(sb.size()), 32'h0);

`ifdef CHANNEL_MONITOR_ARBITER_STALL_COUNT_EN
        reset_pulse();
        check("stall_reset", 32'(stall_count), 32'h0);
        bus.in_valid  = 4'b0001;
        bus.out_ready = 1'b0;
        step();
        bus.in_valid = '0;
        repeat (7) step();
        check("stall_seven", 32'(stall_count), 32'd7);
        repeat (65540) step();
        check("stall_saturate", 32'(stall_count), 32'hFFFF);
        bus.out_ready = 1'b1;
        step();
        step();
        check("stall_no_decrement", 32'(stall_count), 32'hFFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
